sram_controller: RTL

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_pkg.sv | 26 ++
 rtl/sram_phase_counter.sv | 31 +++
 rtl/sram_controller.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared types and constants for the pipeline-facing 16-bit SRAM controller.
package sram_pkg;

    localparam logic [31:0] ADDR_BASE_DEFAULT = 32'd1024;
    localparam int          SRAM_AW           = 18;
    localparam int          SRAM_DW           = 16;
    localparam int          WORD_W            = SRAM_AW - 1;
    localparam int          CNT_W             = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } sram_state_e;

    // Byte address to halfword address; the low two byte-offset bits drop out.
    function automatic logic [SRAM_AW-1:0] halfword_addr(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic        upper
    );
        return {WORD_W'((addr - base) >> 32'd2), upper};
    endfunction

endpackage

// File: rtl/sram_phase_counter.sv
// Loadable cycle counter; tc flags the last cycle of an access phase.
module sram_phase_counter
    import sram_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_value,
    input  logic [CNT_W-1:0] terminal,
    output logic             tc
);

    logic [CNT_W-1:0] count_r;

    // Phase cycle count: load wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= load_value;
        end else if (en) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign tc = (count_r == terminal);

endmodule

// File: rtl/sram_controller.sv
// MEM-stage controller turning one 32-bit access into two 16-bit SRAM phases.
module sram_controller
    import sram_pkg::*;
#(
    parameter int          ACCESS_CYCLES = 2,
    parameter logic [31:0] ADDR_BASE     = ADDR_BASE_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_we_n
);

    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(ACCESS_CYCLES - 1);

    sram_state_e         state_r;
    logic                op_write_r;
    logic [31:0]         addr_r;
    logic [31:0]         data_r;
    logic [31:0]         read_data_r;
    logic [SRAM_AW-1:0]  sram_addr_r;
    logic [SRAM_DW-1:0]  dq_out_r;
    logic                dq_oe_r;
    logic                we_n_r;

    logic                cnt_load_s;
    logic                cnt_en_s;
    logic                cnt_tc_s;
    logic                ready_s;

    sram_phase_counter u_phase_counter (
        .clk        (clk),
        .rst_n      (rst),
        .load       (cnt_load_s),
        .en         (cnt_en_s),
        .load_value ({CNT_W{1'b0}}),
        .terminal   (TERMINAL),
        .tc         (cnt_tc_s)
    );

    // Counter is held at zero outside the phases and reloaded on each phase change.
    always_comb begin
        cnt_load_s = 1'b1;
        cnt_en_s   = 1'b0;
        case (state_r)
            LOW, HIGH: begin
                cnt_load_s = cnt_tc_s;
                cnt_en_s   = ~cnt_tc_s;
            end
            default: begin
                cnt_load_s = 1'b1;
                cnt_en_s   = 1'b0;
            end
        endcase
    end

    // Pipeline stall: only a quiet IDLE or the DONE cycle lets the pipeline advance.
    always_comb begin
        ready_s = 1'b0;
        case (state_r)
            IDLE:    ready_s = ~(rd_en | wr_en);
            LOW:     ready_s = 1'b0;
            HIGH:    ready_s = 1'b0;
            DONE:    ready_s = 1'b1;
            default: ready_s = 1'b0;
        endcase
    end

    // Access FSM with registered SRAM pins and load result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            op_write_r  <= 1'b0;
            addr_r      <= 32'd0;
            data_r      <= 32'd0;
            read_data_r <= 32'd0;
            sram_addr_r <= {SRAM_AW{1'b0}};
            dq_out_r    <= {SRAM_DW{1'b0}};
            dq_oe_r     <= 1'b0;
            we_n_r      <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (wr_en || rd_en) begin
                        state_r     <= LOW;
                        op_write_r  <= wr_en;
                        addr_r      <= address;
                        data_r      <= write_data;
                        sram_addr_r <= halfword_addr(address, ADDR_BASE, 1'b0);
                        if (wr_en) begin
                            dq_out_r <= write_data[15:0];
                            dq_oe_r  <= 1'b1;
                            we_n_r   <= 1'b0;
                        end else begin
                            dq_out_r <= {SRAM_DW{1'b0}};
                            dq_oe_r  <= 1'b0;
                            we_n_r   <= 1'b1;
                        end
                    end
                end
                LOW: begin
                    if (cnt_tc_s) begin
                        state_r     <= HIGH;
                        sram_addr_r <= halfword_addr(addr_r, ADDR_BASE, 1'b1);
                        if (op_write_r) begin
                            dq_out_r <= data_r[31:16];
                        end else begin
                            read_data_r[15:0] <= sram_dq_in;
                        end
                    end
                end
                HIGH: begin
                    if (cnt_tc_s) begin
                        state_r  <= DONE;
                        dq_out_r <= {SRAM_DW{1'b0}};
                        dq_oe_r  <= 1'b0;
                        we_n_r   <= 1'b1;
                        if (!op_write_r) begin
                            read_data_r[31:16] <= sram_dq_in;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign read_data   = read_data_r;
    assign ready       = ready_s;
    assign sram_addr   = sram_addr_r;
    assign sram_dq_out = dq_out_r;
    assign sram_dq_oe  = dq_oe_r;
    assign sram_we_n   = we_n_r;

endmodule
